arilla_bus_arbiter: RTL and testbench
=====================================

Name: arilla_bus_arbiter

Overview:
N-controller to one-peripheral-segment arbiter for the arilla bus. It sits between several bus controllers (core load/store, debug module, DMA) and the shared peripheral side. It grants one controller at a time using round-robin priority and holds the grant across wait states. It also routes responses back to the granted controller and adds timeout and unmapped-access error reporting that the plain bus lacks.

Parameters:
NumControllers, 2, number of controller channels (1..16)
DataWidth, 32, data bits per word
ByteAddressWidth, 32, byte address width
ByteSize, 8, bits per byte lane
TimeoutCycles, 16, wait-state limit before forced completion with error; 0 disables the timeout
(derived: BytesPerWord=DataWidth/ByteSize; AW=ByteAddressWidth-clog2(BytesPerWord); BE=BytesPerWord; N=NumControllers)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
c_read  in  N  per-controller read strobe
c_write  in  N  per-controller write strobe
c_address  in  N*AW  per-controller word address, channel i at [i*AW +: AW]
c_byte_enable  in  N*BE  per-controller byte enables
c_data_ctp  in  N*DW  per-controller write data
c_data_ptc  out  DW  read data, broadcast to all channels
c_available  out  N  per-controller completion; only the granted bit can be 1
c_hit  out  N  m_hit routed to the granted channel; 0 elsewhere
c_intercept  out  N  m_intercept routed to the granted channel; 0 elsewhere
c_error  out  N  one-cycle error pulse to the granted channel
grant  out  N  one-hot registered grant; all zero when idle
m_read  out  1  forwarded read
m_write  out  1  forwarded write
m_address  out  AW  forwarded word address
m_byte_enable  out  BE  forwarded byte enables
m_data_ctp  out  DW  forwarded write data
m_data_ptc  in  DW  peripheral read data
m_available  in  1  peripheral completion / no wait state
m_hit  in  1  some peripheral decoded the address
m_intercept  in  1  access intercepted (debug)

Behaviour:
- Request of channel i: req[i] = c_read[i] | c_write[i].
- Reset values: state IDLE, grant=0, rr pointer=0, timeout counter=0, c_available=0, c_error=0. m_read=m_write=0. m_address, m_byte_enable and m_data_ctp are all ones, matching the bus idle pull-ups.
- While grant=0, all m_* outputs hold the idle values above.
- c_data_ptc = m_data_ptc always (combinational).
- IDLE: if any req, select the first requesting channel at or after the pointer (wrapping modulo N), register it into grant, then go to GRANT. If no req, stay in IDLE.
- Latency: a request in cycle k drives the m_ strobes in cycle k+1 at the earliest.
- GRANT, channel g:
  - m_* = channel g fields, forwarded combinationally and unmodified; read and write both set are passed through as-is.
  - c_available[g] = m_available & req[g]. c_hit[g] = m_hit. c_intercept[g] = m_intercept.
- Completion: m_available & req[g].
  - c_error[g]=1 in that cycle if m_hit=0 and m_intercept=0 (unmapped access).
  - Next cycle: state IDLE, grant=0, pointer=(g+1) mod N, counter=0.
  - A back-to-back access therefore always costs one idle cycle.
- Wait state: req[g] & !m_available. Counter increments, saturating.
- Timeout: when the counter reaches TimeoutCycles-1 during a wait state (and TimeoutCycles≠0), force completion. In that cycle c_available[g]=1 and c_error[g]=1, with c_data_ptc undefined. Next cycle: IDLE, pointer advances.
- Abandon: if req[g] drops before completion, return to IDLE next cycle. Pointer is unchanged, no error.
- Controller obligation: address, byte enables and data stay stable while req is high. The arbiter does not latch them.
- Requests of non-granted channels are ignored (they see c_available=0) until they win arbitration.
- N=1: the arbiter degenerates to the one-cycle grant plus timeout/error logic; the pointer stays 0.
- Reset asserted mid-transaction: outputs return to reset values at the next edge. No c_error and no c_available pulse.

Test Plan:
- N=2, ch0 read addr 0x10 with m_available=1, m_hit=1, m_data_ptc=0xDEADBEEF -> grant=01 the cycle after the request; m_read=1 and m_address=0x10 for one cycle; c_available=01 and c_data_ptc=0xDEADBEEF; c_error=0; grant=00 next.
- N=4, all four channels request continuously, each completing in one cycle -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (fair rotation).
- ch1 write with m_available held low 3 cycles, TimeoutCycles=16 -> grant held 4 cycles; m_write stable; completes on the 4th cycle; c_error=0.
- m_available held low forever, TimeoutCycles=16 -> c_available[g]=1 and c_error[g]=1 on the 16th granted cycle; next request from the other channel is granted.
- Completion with m_hit=0, m_intercept=0 -> c_error pulse. Same access with m_intercept=1 -> no error, c_intercept[g]=1.
- rst asserted during a wait state -> next cycle grant=0, m_read=0, m_address all ones, no c_error; ch0 request after reset is granted first.

Source files
------------

// File: rtl/arilla_bus_arbiter_if.sv
// Controller-side and peripheral-side signals of the arilla bus arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding bus.
interface arilla_bus_arbiter_if #(
  parameter int NumControllers = 2,
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 30,
  parameter int ByteEnables    = 4
);
  logic [NumControllers-1:0]             c_read;
  logic [NumControllers-1:0]             c_write;
  logic [NumControllers*AddrWidth-1:0]   c_address;
  logic [NumControllers*ByteEnables-1:0] c_byte_enable;
  logic [NumControllers*DataWidth-1:0]   c_data_ctp;
  logic [DataWidth-1:0]                  c_data_ptc;
  logic [NumControllers-1:0]             c_available;
  logic [NumControllers-1:0]             c_hit;
  logic [NumControllers-1:0]             c_intercept;
  logic [NumControllers-1:0]             c_error;
  logic [NumControllers-1:0]             grant;

  logic                                  m_read;
  logic                                  m_write;
  logic [AddrWidth-1:0]                  m_address;
  logic [ByteEnables-1:0]                m_byte_enable;
  logic [DataWidth-1:0]                  m_data_ctp;
  logic [DataWidth-1:0]                  m_data_ptc;
  logic                                  m_available;
  logic                                  m_hit;
  logic                                  m_intercept;

  modport master (
    input  c_read, c_write, c_address, c_byte_enable, c_data_ctp,
    input  m_data_ptc, m_available, m_hit, m_intercept,
    output c_data_ptc, c_available, c_hit, c_intercept, c_error, grant,
    output m_read, m_write, m_address, m_byte_enable, m_data_ctp
  );

  modport slave (
    output c_read, c_write, c_address, c_byte_enable, c_data_ctp,
    output m_data_ptc, m_available, m_hit, m_intercept,
    input  c_data_ptc, c_available, c_hit, c_intercept, c_error, grant,
    input  m_read, m_write, m_address, m_byte_enable, m_data_ctp
  );
endinterface

// File: rtl/arilla_bus_arbiter.sv
// Round-robin N-controller arbiter for one arilla peripheral segment, with
// wait-state timeout and unmapped-access error reporting.
module arilla_bus_arbiter #(
  parameter int NumControllers   = 2,
  parameter int DataWidth        = 32,
  parameter int ByteAddressWidth = 32,
  parameter int ByteSize         = 8,
  parameter int TimeoutCycles    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  arilla_bus_arbiter_if.master bus
);
  localparam int N   = NumControllers;
  localparam int DW  = DataWidth;
  localparam int BPW = DataWidth / ByteSize;
  localparam int AW  = ByteAddressWidth - $clog2(BPW);
  localparam int BE  = BPW;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [N-1:0]    req;
  logic [N-1:0]    pick;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   ptr_adv;
  logic            req_g;
  logic            done;
  logic            tmo;
  int              pick_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign req[gi] = bus.c_read[gi] | bus.c_write[gi];
  end

  // First requester at or after the pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_idx = 0;
    for (int k = 0; k < N; k++) begin
      pick_idx = int'(ptr_reg) + k;
      if (pick_idx >= N) pick_idx = pick_idx - N;
      if (pick == '0 && req[pick_idx]) pick[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_reg[i]) gidx = PW'(i);
    end
  end

  assign ptr_adv = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  assign req_g   = |(req & grant_reg);
  assign done    = (state_reg == GRANT) && req_g && bus.m_available;
  // The counter sits at n-1 during the n-th granted cycle.
  assign tmo     = (TimeoutCycles != 0) && (state_reg == GRANT) && req_g &&
                   !bus.m_available && (cnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (|req) begin
          state_next = GRANT;
          grant_next = pick;
        end
      end
      GRANT: begin
        if (done || tmo) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = ptr_adv;
          cnt_next   = '0;
        end else if (!req_g) begin
          // Abandoned access: no error, pointer left where it was.
          state_next = IDLE;
          grant_next = '0;
          cnt_next   = '0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_comb begin
    bus.c_data_ptc    = bus.m_data_ptc;
    bus.grant         = grant_reg;
    bus.m_read        = 1'b0;
    bus.m_write       = 1'b0;
    bus.m_address     = '1;
    bus.m_byte_enable = '1;
    bus.m_data_ctp    = '1;
    bus.c_available   = '0;
    bus.c_hit         = '0;
    bus.c_intercept   = '0;
    bus.c_error       = '0;
    if (state_reg == GRANT) begin
      for (int i = 0; i < N; i++) begin
        if (grant_reg[i]) begin
          bus.m_read        = bus.c_read[i];
          bus.m_write       = bus.c_write[i];
          bus.m_address     = bus.c_address[i*AW +: AW];
          bus.m_byte_enable = bus.c_byte_enable[i*BE +: BE];
          bus.m_data_ctp    = bus.c_data_ctp[i*DW +: DW];
        end
      end
      bus.c_hit       = grant_reg & {N{bus.m_hit}};
      bus.c_intercept = grant_reg & {N{bus.m_intercept}};
      // A reset landing on a completing cycle must not leak a completion pulse.
      if (!rst) begin
        bus.c_available = grant_reg & {N{done | tmo}};
        bus.c_error     = grant_reg & {N{tmo | (done & !bus.m_hit & !bus.m_intercept)}};
      end
    end
  end
endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Randomized and directed checks of arilla_bus_arbiter (4 controllers, 16-cycle timeout)
// against a cycle-level reference model of the arbitration rules.
module tb_arilla_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int BE = 4;
  localparam int TO = 16;
  localparam int VW = 5 * N + 2 + AW + BE + 2 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arilla_bus_arbiter_if #(.NumControllers(N), .DataWidth(DW), .AddrWidth(AW), .ByteEnables(BE)) bus ();

  arilla_bus_arbiter #(
    .NumControllers(N), .DataWidth(DW), .ByteAddressWidth(32), .ByteSize(8), .TimeoutCycles(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: granted channel (-1 when idle), rotation pointer,
  // and 1-based count of cycles the current grant has lasted.
  int mdl_g = -1;
  int mdl_ptr = 0;
  int mdl_cycles = 0;

  logic [VW-1:0] exp_v, act_v;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.grant, bus.c_available, bus.c_error, bus.c_hit, bus.c_intercept,
            bus.m_read, bus.m_write, bus.m_address, bus.m_byte_enable, bus.m_data_ctp,
            bus.c_data_ptc};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [N-1:0] g1, av, er, hi, ic;
    logic rd, wr;
    logic [AW-1:0] a;
    logic [BE-1:0] b;
    logic [DW-1:0] d;
    bit rq, dn, tm;
    g1 = '0; av = '0; er = '0; hi = '0; ic = '0;
    rd = 1'b0; wr = 1'b0; a = '1; b = '1; d = '1;
    if (mdl_g >= 0) begin
      rq = bus.c_read[mdl_g] || bus.c_write[mdl_g];
      dn = rq && bus.m_available;
      tm = rq && !bus.m_available && (mdl_cycles == TO);
      g1[mdl_g] = 1'b1;
      rd = bus.c_read[mdl_g];
      wr = bus.c_write[mdl_g];
      a  = bus.c_address[mdl_g*AW +: AW];
      b  = bus.c_byte_enable[mdl_g*BE +: BE];
      d  = bus.c_data_ctp[mdl_g*DW +: DW];
      hi[mdl_g] = bus.m_hit;
      ic[mdl_g] = bus.m_intercept;
      if (!rst) begin
        av[mdl_g] = dn || tm;
        er[mdl_g] = tm || (dn && !bus.m_hit && !bus.m_intercept);
      end
    end
    return {g1, av, er, hi, ic, rd, wr, a, b, d, bus.m_data_ptc};
  endfunction

  function automatic void model_update();
    bit rq, dn, tm;
    int c;
    if (rst) begin
      mdl_g = -1; mdl_ptr = 0; mdl_cycles = 0;
    end else if (mdl_g < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (mdl_ptr + k) % N;
        if (mdl_g < 0 && (bus.c_read[c] || bus.c_write[c])) begin
          mdl_g = c;
          mdl_cycles = 1;
        end
      end
    end else begin
      rq = bus.c_read[mdl_g] || bus.c_write[mdl_g];
      dn = rq && bus.m_available;
      tm = rq && !bus.m_available && (mdl_cycles == TO);
      if (dn || tm) begin
        mdl_ptr = (mdl_g + 1) % N;
        mdl_g = -1;
      end else if (!rq) begin
        mdl_g = -1;
      end else begin
        mdl_cycles++;
      end
    end
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BE-1:0] b, input logic [DW-1:0] d);
    bus.c_read[ch] = rd;
    bus.c_write[ch] = wr;
    bus.c_address[ch*AW +: AW] = a;
    bus.c_byte_enable[ch*BE +: BE] = b;
    bus.c_data_ctp[ch*DW +: DW] = d;
  endtask

  task automatic clear_req(input int ch);
    bus.c_read[ch] = 1'b0;
    bus.c_write[ch] = 1'b0;
  endtask

  task automatic set_periph(input bit av, input bit hit, input bit icp, input logic [DW-1:0] d);
    bus.m_available = av;
    bus.m_hit = hit;
    bus.m_intercept = icp;
    bus.m_data_ptc = d;
  endtask

  task automatic test_reset();
    bus.c_read = '0; bus.c_write = '0; bus.c_address = '0;
    bus.c_byte_enable = '0; bus.c_data_ctp = '0;
    set_periph(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL reset model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      tests++;
      if ({bus.grant, bus.m_read, bus.m_write, bus.m_address, bus.c_available, bus.c_error} !==
          {4'b0000, 2'b00, {AW{1'b1}}, 4'b0000, 4'b0000}) begin
        fails++; $display("FAIL reset idle cyc %0d: grant %b m_read %b m_address %h", cyc,
                          bus.grant, bus.m_read, bus.m_address);
      end
      step();
    end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_single_read();
    logic [DW+AW+12:0] exp_d, act_d;
    set_periph(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
    set_req(0, 1'b1, 1'b0, 30'h10, 4'hF, 32'h0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL single_read model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      if (cyc != 1) begin
        tests++;
        if (bus.grant !== 4'b0000) begin
          fails++; $display("FAIL single_read idle grant cyc %0d: got %b expected 0000", cyc, bus.grant);
        end
      end else begin
        exp_d = {4'b0001, 1'b1, 30'h10, 4'b0001, 4'b0000, 32'hDEADBEEF};
        act_d = {bus.grant, bus.m_read, bus.m_address, bus.c_available, bus.c_error, bus.c_data_ptc};
        tests++;
        if (act_d !== exp_d) begin
          fails++; $display("FAIL single_read access: got %h expected %h", act_d, exp_d);
        end
      end
      step();
      if (cyc == 1) clear_req(0);
    end
    $display("[TB] single read checked");
  endtask

  task automatic test_rotation();
    logic [N-1:0] rot_exp [9];
    rot_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_periph(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
    for (int ch = 0; ch < N; ch++) set_req(ch, 1'b1, 1'b0, AW'(ch + 1), 4'hF, 32'h0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL rotation model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      if (cyc >= 1) begin
        tests++;
        if (bus.grant !== rot_exp[cyc-1]) begin
          fails++; $display("FAIL rotation grant cyc %0d: got %b expected %b", cyc, bus.grant, rot_exp[cyc-1]);
        end
      end
      step();
    end
    bus.c_read = '0; bus.c_write = '0;
    step();
    $display("[TB] rotation checked");
  endtask

  task automatic test_wait_states();
    int gcount = 0;
    bit done = 0;
    bit err = 0;
    set_periph(1'b0, 1'b1, 1'b0, 32'h5555_AAAA);
    set_req(1, 1'b0, 1'b1, 30'h20, 4'h3, 32'h1234_5678);
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      bus.m_available = (gcount == 3);
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL wait_states model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      if (bus.grant === 4'b0010) gcount++;
      if (bus.c_error !== 4'b0000) err = 1;
      if (bus.c_available[1] === 1'b1) done = 1;
      step();
      if (done) clear_req(1);
    end
    tests++;
    if ({done, gcount[3:0], err} !== {1'b1, 4'd4, 1'b0}) begin
      fails++; $display("FAIL wait_states summary: done %0d grant_cycles %0d err %0d, expected 1 4 0",
                        done, gcount, err);
    end
    step();
    $display("[TB] wait states checked");
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit seen = 0;
    logic [N-1:0] err_at = '0;
    set_periph(1'b0, 1'b1, 1'b0, 32'h0);
    set_req(2, 1'b1, 1'b0, 30'h30, 4'hF, 32'h0);
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL timeout model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      if (bus.grant[2] === 1'b1) cnt++;
      if (bus.c_available[2] === 1'b1) begin
        seen = 1;
        err_at = bus.c_error;
      end
      step();
      if (cyc == 2) set_req(1, 1'b1, 1'b0, 30'h31, 4'hF, 32'h0);
      if (seen) clear_req(2);
    end
    tests++;
    if (!seen || cnt != TO || err_at !== 4'b0100) begin
      fails++; $display("FAIL timeout completion: seen %0d after %0d granted cycles c_error %b, expected 1 %0d 0100",
                        seen, cnt, err_at, TO);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL timeout follow model j %0d: got %h expected %h", j, act_v, exp_v);
      end
      if (j == 1) begin
        tests++;
        if (bus.grant !== 4'b0010) begin
          fails++; $display("FAIL timeout next grant: got %b expected 0010", bus.grant);
        end
      end
      step();
      if (j == 1) bus.m_available = 1'b1;
      if (j == 2) clear_req(1);
    end
    step();
    $display("[TB] timeout checked");
  endtask

  task automatic test_error();
    logic [4*N-1:0] exp_d, act_d;
    bit granted;
    for (int p = 0; p < 2; p++) begin
      granted = 0;
      set_periph(1'b1, 1'b0, p[0], 32'hCAFE_0000 + 32'(p));
      set_req(0, 1'b1, 1'b0, 30'h40, 4'hF, 32'h0);
      for (int cyc = 0; cyc < 6 && !granted; cyc++) begin
        @(negedge clk);
        exp_v = model_vec(); act_v = dut_vec(); tests++;
        if (act_v !== exp_v) begin
          fails++; $display("FAIL error model p %0d cyc %0d: got %h expected %h", p, cyc, act_v, exp_v);
        end
        if (bus.grant !== 4'b0000) begin
          granted = 1;
          exp_d = {4'b0001, 4'b0001, (p == 0) ? 4'b0001 : 4'b0000, (p == 0) ? 4'b0000 : 4'b0001};
          act_d = {bus.grant, bus.c_available, bus.c_error, bus.c_intercept};
          tests++;
          if (act_d !== exp_d) begin
            fails++; $display("FAIL error access intercept=%0d: got %h expected %h", p, act_d, exp_d);
          end
        end
        step();
        if (granted) clear_req(0);
      end
      tests++;
      if (!granted) begin
        fails++; $display("FAIL error grant intercept=%0d: got no grant, expected grant within 6 cycles", p);
      end
      step();
    end
    $display("[TB] error reporting checked");
  endtask

  task automatic test_reset_mid();
    bit granted = 0;
    set_periph(1'b0, 1'b1, 1'b0, 32'h0);
    set_req(1, 1'b1, 1'b0, 30'h50, 4'hF, 32'h0);
    for (int cyc = 0; cyc < 6 && !granted; cyc++) begin
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL reset_mid model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      if (bus.grant === 4'b0010) granted = 1;
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    exp_v = model_vec(); act_v = dut_vec(); tests++;
    if (act_v !== exp_v) begin
      fails++; $display("FAIL reset_mid during reset: got %h expected %h", act_v, exp_v);
    end
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 30'h60, 4'hF, 32'h0);
    set_req(3, 1'b1, 1'b0, 30'h63, 4'hF, 32'h0);
    @(negedge clk);
    exp_v = model_vec(); act_v = dut_vec(); tests++;
    if (act_v !== exp_v) begin
      fails++; $display("FAIL reset_mid after reset model: got %h expected %h", act_v, exp_v);
    end
    tests++;
    if ({bus.grant, bus.m_read, bus.m_address, bus.c_error, bus.c_available} !==
        {4'b0000, 1'b0, {AW{1'b1}}, 4'b0000, 4'b0000}) begin
      fails++; $display("FAIL reset_mid idle: grant %b m_read %b m_address %h c_error %b, expected 0000 0 all-ones 0000",
                        bus.grant, bus.m_read, bus.m_address, bus.c_error);
    end
    step();
    @(negedge clk);
    exp_v = model_vec(); act_v = dut_vec(); tests++;
    if (act_v !== exp_v) begin
      fails++; $display("FAIL reset_mid regrant model: got %h expected %h", act_v, exp_v);
    end
    tests++;
    if (bus.grant !== 4'b0001) begin
      fails++; $display("FAIL reset_mid first grant: got %b expected 0001", bus.grant);
    end
    step();
    bus.c_read = '0; bus.c_write = '0;
    bus.m_available = 1'b1;
    step();
    step();
    $display("[TB] reset during wait checked");
  endtask

  task automatic test_random();
    bit stall = 0;
    bit ctl_done [N];
    int r;
    int errs_before = fails;
    for (int ch = 0; ch < N; ch++) ctl_done[ch] = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc % 60 == 0) stall = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      for (int ch = 0; ch < N; ch++) begin
        if (bus.c_read[ch] || bus.c_write[ch]) begin
          if (ctl_done[ch] || $urandom_range(0, 39) == 0) clear_req(ch);
        end else if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 9);
          set_req(ch, r < 5 || r == 9, r >= 5, AW'($urandom), BE'($urandom), $urandom);
        end else begin
          bus.c_address[ch*AW +: AW] = AW'($urandom);
        end
      end
      set_periph(stall ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) == 0, $urandom);
      @(negedge clk);
      exp_v = model_vec(); act_v = dut_vec(); tests++;
      if (act_v !== exp_v) begin
        fails++; $display("FAIL random model cyc %0d: got %h expected %h", cyc, act_v, exp_v);
      end
      for (int ch = 0; ch < N; ch++) ctl_done[ch] = (bus.c_available[ch] === 1'b1);
      step();
    end
    rst = 1'b0;
    $display("[TB] random traffic checked, %0d new failures", fails - errs_before);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rotation();
    test_wait_states();
    test_timeout();
    test_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d tests expected completion", tests);
    $fatal(1, "watchdog expired");
  end
endmodule
